// File: rtl/ascii_hex_parser_if.sv
// ascii_hex_parser_if
//   Groups the character input strobe and the parsed-result outputs of
//   ascii_hex_parser into one bundle. Clock and reset stay outside.
//
//   Signals:
//     char_in       [7:0]  received ASCII byte
//     char_valid           one-cycle strobe qualifying char_in
//     number        [15:0] last completed operand
//     number_valid         one-cycle pulse, number updated the same cycle
//     command       [2:0]  last decoded operation code
//     command_valid        one-cycle pulse, command updated the same cycle
//     digit_count   [2:0]  hex digits currently pending (0..4)
//     parse_error          one-cycle pulse on a rejected character
//
//   Modports:
//     master  character source (UART side / testbench)
//     slave   the parser itself
interface ascii_hex_parser_if;
    logic [7:0]  char_in;
    logic        char_valid;
    logic [15:0] number;
    logic        number_valid;
    logic [2:0]  command;
    logic        command_valid;
    logic [2:0]  digit_count;
    logic        parse_error;

    modport master (
        output char_in, char_valid,
        input  number, number_valid, command, command_valid, digit_count, parse_error
    );

    modport slave (
        input  char_in, char_valid,
        output number, number_valid, command, command_valid, digit_count, parse_error
    );
endinterface

// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser
//   Character-serial parser turning typed ASCII back into calculator
//   operands and operation codes. Up to four hex digits accumulate into a
//   16-bit value; CR/LF or an operator character completes the operand.
//   Operators map to 3-bit command codes:
//     '+' -> 000, '*' -> 001, '&' -> 010, '-' -> 100, '|' -> 101
//   Space is ignored everywhere; any other byte is rejected with a
//   parse_error pulse and discards pending digits. All results and pulses
//   are registered and appear the cycle after the carrying char_valid edge.
//
//   Optional feature (compile-time macro PARSER_BACKSPACE_EN):
//     defined     - backspace (0x08) / DEL (0x7F) removes the last pending
//                   digit; ignored silently when nothing is pending.
//     undefined   - 0x08 / 0x7F are rejected like any other invalid byte.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    ascii_hex_parser_if.slave (character in, results out)
module ascii_hex_parser (
    input  logic                 clk,
    input  logic                 rst_n,
    ascii_hex_parser_if.slave    bus
);

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
`ifdef PARSER_BACKSPACE_EN
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_DEL   = 8'h7F;
`endif
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t      state, state_next;
    logic [15:0] acc, acc_next;
    logic [2:0]  count, count_next;
    logic [15:0] number_q, number_next;
    logic [2:0]  command_q, command_next;
    logic        number_valid_q, number_valid_next;
    logic        command_valid_q, command_valid_next;
    logic        parse_error_q, parse_error_next;

    // Character classification
    logic        is_hex;
    logic [3:0]  nibble;
    logic        is_op;
    logic [2:0]  op_code;

    // NOTE: every variable assigned in an always_comb gets a default at the
    // top, so no path can leave it unassigned and infer a latch.
    always_comb begin
        is_hex = 1'b1;
        nibble = 4'h0;
        if (bus.char_in >= "0" && bus.char_in <= "9") begin
            nibble = bus.char_in[3:0];
        end else if ((bus.char_in >= "A" && bus.char_in <= "F") ||
                     (bus.char_in >= "a" && bus.char_in <= "f")) begin
            // 'A'/'a' have low nibble 1, so +9 yields 0xA..0xF
            nibble = bus.char_in[3:0] + 4'd9;
        end else begin
            is_hex = 1'b0;
        end
    end

    always_comb begin
        is_op   = 1'b1;
        op_code = 3'b000;
        case (bus.char_in)
            "+":     op_code = 3'b000;
            "*":     op_code = 3'b001;
            "&":     op_code = 3'b010;
            "-":     op_code = 3'b100;
            "|":     op_code = 3'b101;
            default: is_op   = 1'b0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_next         = state;
        acc_next           = acc;
        count_next         = count;
        number_next        = number_q;
        command_next       = command_q;
        number_valid_next  = 1'b0;
        command_valid_next = 1'b0;
        parse_error_next   = 1'b0;

        if (bus.char_valid) begin
            if (is_hex) begin
                if (count == MAX_DIGITS) begin
                    // A fifth digit overflows the operand: reject and restart
                    parse_error_next = 1'b1;
                    acc_next         = '0;
                    count_next       = '0;
                    state_next       = IDLE;
                end else begin
                    acc_next   = {acc[11:0], nibble};
                    count_next = count + 3'd1;
                    state_next = ACCUM;
                end
            end else if (bus.char_in == CH_CR || bus.char_in == CH_LF) begin
                if (state == ACCUM) begin
                    number_next       = acc;
                    number_valid_next = 1'b1;
                    acc_next          = '0;
                    count_next        = '0;
                    state_next        = IDLE;
                end
            end else if (is_op) begin
                command_next       = op_code;
                command_valid_next = 1'b1;
                // An operator also terminates a pending operand
                if (state == ACCUM) begin
                    number_next       = acc;
                    number_valid_next = 1'b1;
                    acc_next          = '0;
                    count_next        = '0;
                    state_next        = IDLE;
                end
            end else if (bus.char_in == CH_SPACE) begin
                // Space separates tokens visually only; state is untouched
                state_next = state;
`ifdef PARSER_BACKSPACE_EN
            end else if (bus.char_in == CH_BS || bus.char_in == CH_DEL) begin
                if (state == ACCUM) begin
                    acc_next   = {4'h0, acc[15:4]};
                    count_next = count - 3'd1;
                    if (count == 3'd1) begin
                        state_next = IDLE;
                    end
                end
`endif
            end else begin
                parse_error_next = 1'b1;
                acc_next         = '0;
                count_next       = '0;
                state_next       = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            acc             <= '0;
            count           <= '0;
            number_q        <= '0;
            command_q       <= 3'b000;
            number_valid_q  <= 1'b0;
            command_valid_q <= 1'b0;
            parse_error_q   <= 1'b0;
        end else begin
            state           <= state_next;
            acc             <= acc_next;
            count           <= count_next;
            number_q        <= number_next;
            command_q       <= command_next;
            number_valid_q  <= number_valid_next;
            command_valid_q <= command_valid_next;
            parse_error_q   <= parse_error_next;
        end
    end

    assign bus.number        = number_q;
    assign bus.number_valid  = number_valid_q;
    assign bus.command       = command_q;
    assign bus.command_valid = command_valid_q;
    assign bus.digit_count   = count;
    assign bus.parse_error   = parse_error_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// tb_ascii_hex_parser
//   Self-checking bench for ascii_hex_parser. Each driven cycle pushes the
//   expected registered outputs onto a scoreboard queue, tagged with the
//   cycle in which they must be visible; a negedge monitor pops and
//   compares them. Reset behaviour is checked inline by the test tasks.
//   Honours PARSER_BACKSPACE_EN the same way the design does.
module tb_ascii_hex_parser;

    logic clk;
    logic rst_n;
    int   cyc;

    ascii_hex_parser_if bus ();

    ascii_hex_parser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        nv;
        logic        cv;
        logic        err;
        logic [15:0] num;
        logic [2:0]  cmd;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference values of the holding outputs, maintained by the tests
    logic [15:0] exp_num = 16'h0000;
    logic [2:0]  exp_cmd = 3'b000;

    // Scoreboard consumer: compare every record that falls due this cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks += 6;
            if (e.due != cyc)
                $display("FAIL sb_stale: record due cycle %0d seen at cycle %0d", e.due, cyc);
            else
                n_pass++;
            if (bus.number_valid !== e.nv)
                $display("FAIL number_valid @%0d: got %b want %b", cyc, bus.number_valid, e.nv);
            else
                n_pass++;
            if (bus.command_valid !== e.cv)
                $display("FAIL command_valid @%0d: got %b want %b", cyc, bus.command_valid, e.cv);
            else
                n_pass++;
            if (bus.parse_error !== e.err)
                $display("FAIL parse_error @%0d: got %b want %b", cyc, bus.parse_error, e.err);
            else
                n_pass++;
            if (bus.number !== e.num)
                $display("FAIL number @%0d: got %h want %h", cyc, bus.number, e.num);
            else
                n_pass++;
            if (bus.command !== e.cmd || bus.digit_count !== e.cnt)
                $display("FAIL cmd_count @%0d: got cmd %b cnt %0d want cmd %b cnt %0d",
                         cyc, bus.command, bus.digit_count, e.cmd, e.cnt);
            else
                n_pass++;
        end
    end

    // Drive one character (leaves char_valid high so calls chain at full rate)
    task automatic put_char(input logic [7:0] c, input logic nv, input logic cv,
                            input logic err, input logic [2:0] cnt);
        exp_t e;
        bus.char_in    = c;
        bus.char_valid = 1'b1;
        e = '{due: cyc + 1, nv: nv, cv: cv, err: err, num: exp_num, cmd: exp_cmd, cnt: cnt};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle without a character: all pulses must drop
    task automatic idle(input logic [2:0] cnt);
        exp_t e;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        e = '{due: cyc + 1, nv: 1'b0, cv: 1'b0, err: 1'b0, num: exp_num, cmd: exp_cmd, cnt: cnt};
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.number !== 16'h0000 || bus.command !== 3'b000 || bus.digit_count !== 3'd0 ||
            bus.number_valid !== 1'b0 || bus.command_valid !== 1'b0 || bus.parse_error !== 1'b0)
            $display("FAIL reset_state: got num %h cmd %b cnt %0d pulses %b%b%b want 0000 000 0 000",
                     bus.number, bus.command, bus.digit_count,
                     bus.number_valid, bus.command_valid, bus.parse_error);
        else
            n_pass++;
        rst_n = 1'b1;
        idle(3'd0);
    endtask

    task automatic test_number();
        put_char("1", 0, 0, 0, 3'd1);
        put_char("A", 0, 0, 0, 3'd2);
        put_char("3", 0, 0, 0, 3'd3);
        put_char("f", 0, 0, 0, 3'd4);
        exp_num = 16'h1A3F;
        put_char(8'h0D, 1, 0, 0, 3'd0);
        idle(3'd0);
    endtask

    task automatic test_operator();
        put_char("7", 0, 0, 0, 3'd1);
        exp_num = 16'h0007;
        exp_cmd = 3'b000;
        put_char("+", 1, 1, 0, 3'd0);
        exp_cmd = 3'b101;
        put_char("|", 0, 1, 0, 3'd0);
        exp_cmd = 3'b001;
        put_char("*", 0, 1, 0, 3'd0);
        exp_cmd = 3'b010;
        put_char("&", 0, 1, 0, 3'd0);
        put_char("c", 0, 0, 0, 3'd1);
        exp_num = 16'h000C;
        exp_cmd = 3'b100;
        put_char("-", 1, 1, 0, 3'd0);
        idle(3'd0);
    endtask

    task automatic test_overflow();
        put_char("1", 0, 0, 0, 3'd1);
        put_char("2", 0, 0, 0, 3'd2);
        put_char("3", 0, 0, 0, 3'd3);
        put_char("4", 0, 0, 0, 3'd4);
        put_char("5", 0, 0, 1, 3'd0);
        put_char("9", 0, 0, 0, 3'd1);
        exp_num = 16'h0009;
        put_char(8'h0D, 1, 0, 0, 3'd0);
        idle(3'd0);
    endtask

    task automatic test_invalid();
        put_char("4", 0, 0, 0, 3'd1);
        put_char("G", 0, 0, 1, 3'd0);
        put_char(8'h0D, 0, 0, 0, 3'd0);
        put_char(8'h0A, 0, 0, 0, 3'd0);
        idle(3'd0);
    endtask

    task automatic test_space();
        put_char(" ", 0, 0, 0, 3'd0);
        put_char("b", 0, 0, 0, 3'd1);
        put_char(" ", 0, 0, 0, 3'd1);
        put_char("E", 0, 0, 0, 3'd2);
        exp_num = 16'h00BE;
        put_char(8'h0A, 1, 0, 0, 3'd0);
        idle(3'd0);
    endtask

    task automatic test_backspace();
        put_char("A", 0, 0, 0, 3'd1);
        put_char("B", 0, 0, 0, 3'd2);
`ifdef PARSER_BACKSPACE_EN
        put_char(8'h08, 0, 0, 0, 3'd1);
        put_char("C", 0, 0, 0, 3'd2);
        exp_num = 16'h00AC;
        put_char(8'h0D, 1, 0, 0, 3'd0);
        // DEL down to empty, then backspace in IDLE is silently ignored
        put_char("5", 0, 0, 0, 3'd1);
        put_char(8'h7F, 0, 0, 0, 3'd0);
        put_char(8'h08, 0, 0, 0, 3'd0);
        put_char(8'h0D, 0, 0, 0, 3'd0);
`else
        put_char(8'h08, 0, 0, 1, 3'd0);
        put_char("C", 0, 0, 0, 3'd1);
        exp_num = 16'h000C;
        put_char(8'h0D, 1, 0, 0, 3'd0);
        put_char(8'h7F, 0, 0, 1, 3'd0);
`endif
        idle(3'd0);
    endtask

    task automatic test_back_to_back();
        put_char("1", 0, 0, 0, 3'd1);
        exp_num = 16'h0001;
        put_char(8'h0D, 1, 0, 0, 3'd0);
        put_char("2", 0, 0, 0, 3'd1);
        exp_num = 16'h0002;
        put_char(8'h0D, 1, 0, 0, 3'd0);
        exp_cmd = 3'b000;
        put_char("+", 0, 1, 0, 3'd0);
        exp_cmd = 3'b100;
        put_char("-", 0, 1, 0, 3'd0);
        idle(3'd0);
        idle(3'd0);
    endtask

    task automatic test_reset_mid();
        put_char("F", 0, 0, 0, 3'd1);
        put_char("F", 0, 0, 0, 3'd2);
        #2;
        rst_n          = 1'b0;
        bus.char_valid = 1'b0;
        exp_num        = 16'h0000;
        exp_cmd        = 3'b000;
        @(negedge clk);
        n_checks++;
        if (bus.digit_count !== 3'd0 || bus.number !== 16'h0000 || bus.number_valid !== 1'b0)
            $display("FAIL reset_mid: got cnt %0d num %h nv %b want 0 0000 0",
                     bus.digit_count, bus.number, bus.number_valid);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3'd0);
        put_char("1", 0, 0, 0, 3'd1);
        exp_num = 16'h0001;
        put_char(8'h0D, 1, 0, 0, 3'd0);
        idle(3'd0);
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_number();
        test_operator();
        test_overflow();
        test_invalid();
        test_space();
        test_backspace();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: %0d records left, want 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
